// File: rtl/lfsr_arb_pkg.sv
// lfsr_arb_pkg: shared types and helpers for lfsr_arbiter.
package lfsr_arb_pkg;

    typedef enum logic [0:0] {IDLE = 1'b0, SERVE = 1'b1} state_t;

    localparam int MAX_BURST_DEF = 4;
    localparam int BURST_W_DEF   = $clog2(MAX_BURST_DEF + 1);

    function automatic int rot_amt(input int idx, input int width, input int num_req);
        return idx * (width / num_req);
    endfunction

endpackage

// File: rtl/lfsr_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick, lowest index strictly after ptr (wrapping),
// optionally excluding ptr itself.
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          excl,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx
);
    int   j;
    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        // Offset N lands back on ptr, which is skipped when excluded.
        for (int k = 1; k <= N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && req[j] && !(excl && k == N)) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IW'(j);
            end
        end
    end
endmodule

// File: rtl/lfsr_arbiter.sv
// lfsr_arbiter: steers each cycle's LFSR sample to one requester, round-robin with bounded bursts.
// Define LFSR_ARB_ROTATE_EN to rotate each sample left by owner_index*(BITWIDTH/NUM_REQ).
module lfsr_arbiter
    import lfsr_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int BITWIDTH  = 64,
    parameter int MAX_BURST = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [BITWIDTH-1:0] r,
    input  logic [NUM_REQ-1:0]  req,
    output logic [NUM_REQ-1:0]  grant,
    output logic [BITWIDTH-1:0] rand_out,
    output logic                rand_valid,
    output logic                busy
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [IW-1:0]       last_q, last_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [BITWIDTH-1:0] rand_q, rand_d;
    logic                valid_q, valid_d;

    logic [NUM_REQ-1:0]  pick_gnt;
    logic [IW-1:0]       pick_idx;
    logic                serving, own, others, at_max, go_idle, switch_own;
    logic [BITWIDTH-1:0] sample;

    assign serving = (state_q == SERVE);

    rr_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req  (req),
        .ptr  (last_q),
        .excl (serving),
        .gnt  (pick_gnt),
        .idx  (pick_idx)
    );

    always_comb begin
        own        = req[last_q];
        others     = |(req & ~grant_q);
        at_max     = (cnt_q == CW'(MAX_BURST));
        go_idle    = serving ? (!own && !others) : !(|req);
        switch_own = serving ? ((!own || at_max) && others) : (|req);
        state_d    = go_idle ? IDLE : SERVE;
        grant_d    = go_idle ? '0 : (switch_own ? pick_gnt : grant_q);
        last_d     = switch_own ? pick_idx : last_q;
        cnt_d      = go_idle ? '0 : (switch_own ? CW'(1) : (at_max ? cnt_q : cnt_q + CW'(1)));
        valid_d    = !go_idle;
`ifdef LFSR_ARB_ROTATE_EN
        sample     = BITWIDTH'(({r, r} << rot_amt(int'(last_d), BITWIDTH, NUM_REQ)) >> BITWIDTH);
`else
        sample     = r;
`endif
        rand_d     = go_idle ? rand_q : sample;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IW'(NUM_REQ - 1);
            cnt_q   <= '0;
            rand_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            rand_q  <= rand_d;
            valid_q <= valid_d;
        end
    end

    assign grant      = grant_q;
    assign rand_out   = rand_q;
    assign rand_valid = valid_q;
    assign busy       = serving;
endmodule

// File: doc/lfsr_arbiter.md
Name: lfsr_arbiter

Overview:
- Shares one free-running Fibonacci LFSR sample stream among NUM_REQ stochastic-bitstream generators.
- The LFSR has no enable and advances every cycle. The arbiter steers each cycle's sample to exactly one requester, so no two consumers ever see the same sample.
- Round-robin with bounded bursts. Sits between a single fibonacci_lfsr instance and the SBitstream encoders in a generated design.

Parameters:
- NUM_REQ, 4: number of requesters, ≥2.
- BITWIDTH, 64: LFSR/sample width; 20 or 64.
- MAX_BURST, 4: maximum consecutive samples one owner may take while others wait; ≥1.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  reset; synchronous, active-high.
- r  input  BITWIDTH  current LFSR output; new value every cycle.
- req  input  NUM_REQ  per-requester sample request, level-sensitive.
- grant  output  NUM_REQ  one-hot owner of rand_out this cycle; zero when idle.
- rand_out  output  BITWIDTH  registered sample delivered to the granted requester.
- rand_valid  output  1  high exactly when grant is non-zero.
- busy  output  1  high when state is SERVE.

Behaviour:
Reset
- On RST high at an edge: state=IDLE, grant=0, rand_out=0, rand_valid=0, busy=0, burst_cnt=0, last=NUM_REQ-1, so requester 0 wins first.
- RST has priority over every other event, including mid-burst; the request in flight is dropped.

Registered outputs and latency
- grant, rand_out, rand_valid and busy are all registered and update on the same edge.
- Latency is 1 cycle: req sampled at edge k gives grant, rand_out = r(k) and rand_valid at k+1.
- Every delivered sample is r captured at that edge. The owner receives one fresh sample per cycle while granted.

RR pick
- Lowest index strictly after the pointer, wrapping modulo NUM_REQ, among the eligible req bits.

State IDLE
- No req: remain in IDLE, outputs zero.
- Any req: owner = RR pick from last. Go to SERVE, grant owner, deliver sample, burst_cnt=1, last=owner.

State SERVE (owner o, count c)
- req[o]=0, others pending: switch to RR pick from o with no bubble cycle; deliver sample to the new owner, c=1.
- req[o]=0, none pending: go to IDLE; grant, rand_valid and busy go to 0. rand_out holds its last value.
- req[o]=1, c==MAX_BURST, others pending: rotate to RR pick from o, excluding o; deliver sample, c=1.
- req[o]=1, otherwise: keep o, deliver sample, c=min(c+1, MAX_BURST). A sole requester keeps the grant indefinitely.

Invariants
- grant is always one-hot or zero.
- burst_cnt width is clog2(MAX_BURST+1).
- MAX_BURST=1 gives pure per-cycle round-robin.

Optional Feature:
- Macro LFSR_ARB_ROTATE_EN.
- Defined: rand_out = r rotated left by owner_index*(BITWIDTH/NUM_REQ), computed from the owner being granted on that edge. This decorrelates bit positions across consumers.
- Undefined: rand_out = r unmodified.
- Timing and handshake are identical in both builds.

Decomposition:
- Package lfsr_arb_pkg holds:
  - state_t enum {IDLE, SERVE};
  - a localparam for the burst counter width;
  - a rotate-amount helper function.
- Sub-module rr_picker: combinational. Takes the req vector, pointer and exclude-pointer flag; returns the one-hot winner and its index.

Test Plan:
All scenarios use NUM_REQ=4, MAX_BURST=4, BITWIDTH=20, and r driven by the testbench as a cycle counter.
- Reset then req=4'b0001 at edge k: grant=0001, rand_out=k and rand_valid=1 at k+1; grant=0 and busy=0 while RST held.
- req=4'b1111 held: grant goes 0001×4, 0010×4, 0100×4, 1000×4, then 0001 again. Consecutive rand_out values are strictly increasing with no repeats.
- req=4'b0100 alone for 10 cycles: grant stays 0100 all 10 cycles and rand_out takes 10 consecutive distinct values.
- Owner 0001 drops req while req=0100 pending: the next edge gives grant=0100 with rand_valid staying 1 (no bubble).
- RST pulsed mid-burst of owner 0010, then req=1111: grant=0 for one cycle, then 0001 first.
- Build with LFSR_ARB_ROTATE_EN, req=0010, r=20'h00001: rand_out=20'h00020 (rotate by 5). Without the macro, rand_out=20'h00001.
